// File: rtl/median5_window_if.sv
// Sample/window/median bus between the stream source, the median5_window
// front end and the combinational five-input median comparator.
// Signals:
//   in_valid/in_data/flush   sample input and window clear
//   win0..win4               window operands to the comparator (win0 newest)
//   med_idx                  comparator result, 0..4 selects win0..win4
//   full/out_valid/out_data  fill status and registered median output
// Modports:
//   master  the environment (sample source plus comparator)
//   slave   the median5_window front end
interface median5_window_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       flush;
    logic [7:0] win0;
    logic [7:0] win1;
    logic [7:0] win2;
    logic [7:0] win3;
    logic [7:0] win4;
    logic [2:0] med_idx;
    logic       full;
    logic       out_valid;
    logic [7:0] out_data;

    modport master (
        output in_valid, in_data, flush, med_idx,
        input  win0, win1, win2, win3, win4,
        input  full, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, flush, med_idx,
        output win0, win1, win2, win3, win4,
        output full, out_valid, out_data
    );
endinterface

// File: rtl/median5_window.sv
// Five-deep sliding window feeding an external median comparator; the
// selected window value is registered as the filter output.
// Ports: clk, rst_n (async active-low), bus (median5_window_if.slave).
// Option: MED5_EDGE_REPLICATE_EN - first accept fills the whole window.
module median5_window (
    input  logic               clk,
    input  logic               rst_n,
    median5_window_if.slave    bus
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } fill_t;

    logic [7:0] win_q [5];
    logic [2:0] cnt_q;
    logic [2:0] cnt_d;
    logic       upd_q;
    logic       upd_d;
    logic       ov_q;
    logic [7:0] od_q;
    logic [7:0] sel;
    logic       load_all;
    fill_t      state;

    assign state = (cnt_q == 3'd5) ? FULL : FILL;

    // Replicating the first sample into every tap makes the window
    // full at once, so a median is available from the first accept.
`ifdef MED5_EDGE_REPLICATE_EN
    assign load_all = (cnt_q == 3'd0);
`else
    assign load_all = 1'b0;
`endif

    always_comb begin
        cnt_d = cnt_q;
        upd_d = 1'b0;
        if (bus.flush) begin
            cnt_d = 3'd0;
        end else if (bus.in_valid) begin
            if (load_all) begin
                cnt_d = 3'd5;
                upd_d = 1'b1;
            end else begin
                cnt_d = (state == FULL) ? 3'd5 : cnt_q + 3'd1;
                upd_d = (cnt_d == 3'd5);
            end
        end
    end

    // Indices 5..7 are illegal comparator results and select zero.
    always_comb begin
        sel = 8'h00;
        case (bus.med_idx)
            3'd0:    sel = win_q[0];
            3'd1:    sel = win_q[1];
            3'd2:    sel = win_q[2];
            3'd3:    sel = win_q[3];
            3'd4:    sel = win_q[4];
            default: sel = 8'h00;
        endcase
    end

    // The capture uses the pre-edge window, so a back-to-back accept on
    // the same edge cannot disturb the median being registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) win_q[i] <= 8'h00;
            cnt_q <= 3'd0;
            upd_q <= 1'b0;
            ov_q  <= 1'b0;
            od_q  <= 8'h00;
        end else begin
            cnt_q <= cnt_d;
            upd_q <= upd_d;
            if (bus.flush) begin
                for (int i = 0; i < 5; i++) win_q[i] <= 8'h00;
                ov_q <= 1'b0;
            end else begin
                ov_q <= upd_q;
                if (upd_q) od_q <= sel;
                if (bus.in_valid) begin
                    if (load_all) begin
                        for (int i = 0; i < 5; i++) win_q[i] <= bus.in_data;
                    end else begin
                        for (int i = 4; i > 0; i--) win_q[i] <= win_q[i-1];
                        win_q[0] <= bus.in_data;
                    end
                end
            end
        end
    end

    assign bus.win0      = win_q[0];
    assign bus.win1      = win_q[1];
    assign bus.win2      = win_q[2];
    assign bus.win3      = win_q[3];
    assign bus.win4      = win_q[4];
    assign bus.full      = (state == FULL);
    assign bus.out_valid = ov_q;
    assign bus.out_data  = od_q;

endmodule

// File: tb/tb_median5_window.sv
// Self-checking bench for median5_window: directed scenarios then random
// traffic, compared against a window/median reference model.
module tb_median5_window;

`ifdef MED5_EDGE_REPLICATE_EN
    localparam bit REPL = 1'b1;
`else
    localparam bit REPL = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic force_en;
    logic [2:0] force_idx;

    median5_window_if bus ();

    median5_window dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    // reference state: window (index 0 newest), fill count, pending flag
    logic [7:0] mw [5];
    int         mcnt;
    bit         mupd;
    bit         mov;
    logic [7:0] mod;

    // median position: an element with at most two smaller and at
    // least three smaller-or-equal values (itself included)
    function automatic logic [2:0] med_of(input logic [7:0] a [5]);
        for (int i = 0; i < 5; i++) begin
            int lt;
            int le;
            lt = 0;
            le = 0;
            for (int j = 0; j < 5; j++) begin
                if (a[j] < a[i]) lt++;
                if (a[j] <= a[i]) le++;
            end
            if (lt <= 2 && le >= 3) return 3'(i);
        end
        return 3'd0;
    endfunction

    // comparator stand-in, optionally overridden with a forced index
    logic [7:0] dw [5];
    always_comb begin
        dw[0] = bus.win0;
        dw[1] = bus.win1;
        dw[2] = bus.win2;
        dw[3] = bus.win3;
        dw[4] = bus.win4;
        bus.med_idx = force_en ? force_idx : med_of(dw);
    end

    task automatic chk(input string tag,
                       input logic [39:0] obs,
                       input logic [39:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) mw[i] = 8'h00;
        mcnt = 0;
        mupd = 1'b0;
        mov  = 1'b0;
        mod  = 8'h00;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".win"},
            {bus.win0, bus.win1, bus.win2, bus.win3, bus.win4},
            {mw[0], mw[1], mw[2], mw[3], mw[4]});
        chk({tag, ".full"}, 40'(bus.full), 40'(mcnt == 5));
        chk({tag, ".out_valid"}, 40'(bus.out_valid), 40'(mov));
        chk({tag, ".out_data"}, 40'(bus.out_data), 40'(mod));
    endtask

    // one clock: drive at negedge, advance model at posedge, check at
    // the following negedge
    task automatic step(input string tag, input bit v, input logic [7:0] d,
                        input bit f, input bit fe, input logic [2:0] fi);
        logic [2:0] idx;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.flush    = f;
        force_en     = fe;
        force_idx    = fi;
        @(posedge clk);
        if (f) begin
            for (int i = 0; i < 5; i++) mw[i] = 8'h00;
            mcnt = 0;
            mupd = 1'b0;
            mov  = 1'b0;
        end else begin
            if (mupd) begin
                idx = fe ? fi : med_of(mw);
                mod = (idx < 5) ? mw[idx] : 8'h00;
                mov = 1'b1;
            end else begin
                mov = 1'b0;
            end
            if (v) begin
                if (REPL && mcnt == 0) begin
                    for (int i = 0; i < 5; i++) mw[i] = d;
                    mcnt = 5;
                    mupd = 1'b1;
                end else begin
                    for (int i = 4; i > 0; i--) mw[i] = mw[i-1];
                    mw[0] = d;
                    mcnt = (mcnt < 5) ? mcnt + 1 : 5;
                    mupd = (mcnt == 5);
                end
            end else begin
                mupd = 1'b0;
            end
        end
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic acc(input string tag, input logic [7:0] d);
        step(tag, 1'b1, d, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0);
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        force_en  = 1'b0;
        force_idx = 3'd0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.flush    = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        // fill and slide
        acc("fill0", 8'd10);
        acc("fill1", 8'd50);
        acc("fill2", 8'd30);
        acc("fill3", 8'd20);
        acc("fill4", 8'd40);
        acc("slide", 8'd60);
        idle("slide_cap");
        idle("idle_hold");

        // flush collides with an accept; flush wins
        step("flush", 1'b1, 8'd99, 1'b1, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) acc("post_flush", 8'(11 * (i + 1)));

        // async reset with a capture pending
        acc("pre_rst", 8'd77);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        idle("rst_release");
        idle("rst_idle");

        // illegal comparator index on the update cycle
        for (int i = 0; i < 5; i++) acc("ill_fill", 8'(200 + i));
        step("ill_idx5", 1'b0, 8'h00, 1'b0, 1'b1, 3'd5);
        acc("ill_more", 8'd3);
        step("ill_idx7", 1'b0, 8'h00, 1'b0, 1'b1, 3'd7);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            bit v;
            bit f;
            bit fe;
            v  = ($urandom_range(0, 9) < 7);
            f  = ($urandom_range(0, 19) == 0);
            fe = ($urandom_range(0, 24) == 0);
            step("rand", v, 8'($urandom), f, fe,
                 3'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
